// File: rtl/sstv_tx_sequencer.sv
// sstv_tx_sequencer
//
// Frame sequencer for the SSTV (Martin M1) transmit path. After the image
// buffer reports loaded, it walks leader/break/VIS header, then per line:
// sync, porch, and G/B/R colour scans each followed by a separator. For every
// slot it drives a tone frequency code and paces the pixel provider with
// one-cycle read requests.
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   start     in   image buffer loaded (sampled only in IDLE)
//   px_data   in 8 pixel byte, valid the cycle after px_req
//   px_req    out  one-cycle pulse requesting the next pixel byte
//   freq      out 12 tone frequency in Hz, 0 = silence
//   tone_on   out  tone generator enable
//   busy      out  transmission in progress
//   done      out  frame complete, sticky until rst
//   line_idx  out 8 current line
//
// state      | meaning
// -----------+---------------------------------------------
// IDLE       | silent, waiting for start
// LEADER1    | 1900 Hz leader
// BREAK      | 1200 Hz break
// LEADER2    | 1900 Hz leader
// VIS_START  | 1200 Hz VIS start bit
// VIS_DATA   | 7 VIS code bits LSB first + even parity
// VIS_STOP   | 1200 Hz VIS stop bit
// SYNC       | 1200 Hz line sync
// PORCH      | 1500 Hz porch
// SCAN       | SCANLINE_WIDTH pixel slots of one colour
// SEP        | 1500 Hz separator after each colour scan
// DONE       | silent, frame complete until reset

module sstv_tx_sequencer #(
  parameter int unsigned SCANLINE_WIDTH = 320,
  parameter int unsigned SCANLINE_NUM   = 256,
  parameter logic [6:0]  VIS_CODE       = 7'h2C,
  parameter int unsigned LEADER_CYC     = 30_000_000,
  parameter int unsigned BREAK_CYC      = 1_000_000,
  parameter int unsigned VIS_BIT_CYC    = 3_000_000,
  parameter int unsigned SYNC_CYC       = 486_200,
  parameter int unsigned PORCH_CYC      = 57_200,
  parameter int unsigned PIXEL_CYC      = 45_760
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  px_data,
  output logic        px_req,
  output logic [11:0] freq,
  output logic        tone_on,
  output logic        busy,
  output logic        done,
  output logic [7:0]  line_idx
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEADER1, S_BREAK, S_LEADER2, S_VIS_START, S_VIS_DATA,
    S_VIS_STOP, S_SYNC, S_PORCH, S_SCAN, S_SEP, S_DONE
  } state_t;

  // data bits followed by the even-parity bit, indexed by vis_bit
  localparam logic [7:0]  VIS_WORD  = {^VIS_CODE, VIS_CODE};
  localparam logic [15:0] PX_LAST   = 16'(SCANLINE_WIDTH - 1);
  localparam logic [7:0]  LINE_LAST = 8'(SCANLINE_NUM - 1);

  state_t      state, state_nxt;
  logic [31:0] dur_cnt;
  logic [31:0] seg_len;
  logic        seg_last;
  logic [2:0]  vis_bit;
  logic [1:0]  chan;
  logic [15:0] px_cnt;
  logic [11:0] px_tone;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      dur_cnt  <= '0;
      vis_bit  <= '0;
      chan     <= '0;
      px_cnt   <= '0;
      line_idx <= '0;
      px_tone  <= '0;
    end else begin
      state   <= state_nxt;
      dur_cnt <= seg_last ? 32'd0 : dur_cnt + 32'd1;
      if (state == S_VIS_DATA && seg_last)
        vis_bit <= vis_bit + 3'd1;
      if (state == S_SCAN && seg_last)
        px_cnt <= (px_cnt == PX_LAST) ? 16'd0 : px_cnt + 16'd1;
      if (state == S_SEP && seg_last) begin
        chan <= (chan == 2'd2) ? 2'd0 : chan + 2'd1;
        // last line keeps its index in DONE
        if (chan == 2'd2 && line_idx != LINE_LAST)
          line_idx <= line_idx + 8'd1;
      end
      // byte arrives in slot cycle 1; the tone shows from cycle 2
      if (state == S_SCAN && dur_cnt == 32'd1)
        px_tone <= 12'(20'd1500 + ((20'(px_data) * 20'd3213) >> 10));
    end
  end

  always_comb begin
    seg_len = 32'd1;
    case (state)
      S_LEADER1, S_LEADER2:                 seg_len = LEADER_CYC;
      S_BREAK:                              seg_len = BREAK_CYC;
      S_VIS_START, S_VIS_DATA, S_VIS_STOP:  seg_len = VIS_BIT_CYC;
      S_SYNC:                               seg_len = SYNC_CYC;
      S_PORCH, S_SEP:                       seg_len = PORCH_CYC;
      S_SCAN:                               seg_len = PIXEL_CYC;
      default:                              seg_len = 32'd1;
    endcase
    seg_last = (dur_cnt == seg_len - 32'd1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start) state_nxt = S_LEADER1;
      S_LEADER1:   if (seg_last) state_nxt = S_BREAK;
      S_BREAK:     if (seg_last) state_nxt = S_LEADER2;
      S_LEADER2:   if (seg_last) state_nxt = S_VIS_START;
      S_VIS_START: if (seg_last) state_nxt = S_VIS_DATA;
      S_VIS_DATA:  if (seg_last && vis_bit == 3'd7) state_nxt = S_VIS_STOP;
      S_VIS_STOP:  if (seg_last) state_nxt = S_SYNC;
      S_SYNC:      if (seg_last) state_nxt = S_PORCH;
      S_PORCH:     if (seg_last) state_nxt = S_SCAN;
      S_SCAN:      if (seg_last && px_cnt == PX_LAST) state_nxt = S_SEP;
      S_SEP: begin
        if (seg_last) begin
          if (chan != 2'd2)
            state_nxt = S_SCAN;
          else if (line_idx == LINE_LAST)
            state_nxt = S_DONE;
          else
            state_nxt = S_SYNC;
        end
      end
      S_DONE:      state_nxt = S_DONE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    freq    = 12'd0;
    px_req  = 1'b0;
    tone_on = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      S_LEADER1, S_LEADER2:              freq = 12'd1900;
      S_BREAK, S_VIS_START, S_VIS_STOP,
      S_SYNC:                            freq = 12'd1200;
      S_VIS_DATA:                        freq = VIS_WORD[vis_bit] ? 12'd1100 : 12'd1300;
      S_PORCH, S_SEP:                    freq = 12'd1500;
      S_SCAN: begin
        // first two cycles of a slot keep the previous tone; before the
        // first pixel of a scan that is the porch/separator tone
        if (px_cnt == 16'd0 && dur_cnt < 32'd2)
          freq = 12'd1500;
        else
          freq = px_tone;
        px_req = (dur_cnt == 32'd0);
      end
      default:                           freq = 12'd0;
    endcase
    if (state != S_IDLE && state != S_DONE) begin
      tone_on = 1'b1;
      busy    = 1'b1;
    end
    done = (state == S_DONE);
  end

endmodule
